// File: rtl/taylor_pkg.sv
// Shared definitions for the Taylor-series e^x datapath: checker state
// encoding, strobe-vector bit positions and the 1/n coefficient ROM builder.
package taylor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADED,
    ST_WAIT_M,
    ST_WAIT_R,
    ST_WAIT_A,
    ST_FIN
  } chk_state_e;

  // Bit positions of the load strobes inside the packed strobe vector.
  localparam int STB_I    = 0;
  localparam int STB_INIT = 1;
  localparam int STB_M    = 2;
  localparam int STB_RES  = 3;
  localparam int STB_A    = 4;
  localparam int N_STB    = 5;

  // ROM geometry: one 32-bit slot per possible value of the 5-bit counter.
  localparam int COEF_DEPTH = 32;
  localparam int COEF_W     = 32;

  function automatic logic [COEF_W-1:0] one_val(input int frac);
    return COEF_W'(64'd1 << frac);
  endfunction

  // Entry i holds floor(ONE / i) for 1 <= i < n_terms; all other slots are 0.
  function automatic logic [COEF_DEPTH*COEF_W-1:0] build_coef_rom(input int frac,
                                                                  input int n_terms);
    logic [COEF_DEPTH*COEF_W-1:0] rom;
    rom = '0;
    for (int i = 1; i < n_terms && i < COEF_DEPTH; i++) begin
      rom[i*COEF_W +: COEF_W] = COEF_W'((64'd1 << frac) / 64'(i));
    end
    return rom;
  endfunction

endpackage

// File: rtl/taylor_datapath_if.sv
// Load-strobe control interface between the sequencing controller (master)
// and the Taylor datapath (slave).
//
// Handshake: the controller raises at most one strobe per cycle, each for a
// single cycle; the datapath acts on it at that cycle's rising edge and the
// effect is visible on result the following cycle. Done is combinational so
// the controller sees it during the final ldA cycle, then stays high until
// the next ldI/ldInit. err is sticky until an accepted ldI.
interface taylor_datapath_if #(parameter int WIDTH = 16);
  import taylor_pkg::*;

  logic [WIDTH-1:0] x_in;
  logic             ldI;
  logic             ldInit;
  logic             ldM;
  logic             ldRes;
  logic             ldA;
  logic             Done;
  logic [WIDTH-1:0] result;
  logic             err;
  chk_state_e       dbg_state;

  modport master (
    output x_in, ldI, ldInit, ldM, ldRes, ldA,
    input  Done, result, err, dbg_state
  );

  modport slave (
    input  x_in, ldI, ldInit, ldM, ldRes, ldA,
    output Done, result, err, dbg_state
  );

endinterface

// File: rtl/strobe_checker.sv
// Protocol checker for the load strobes: tracks where the controller is in
// the evaluation sequence, accepts only the one strobe legal in that state,
// and raises a sticky err on anything else.
module strobe_checker
  import taylor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_STB-1:0] stb,
  input  logic             n_last,
  output logic             accept,
  output logic             err,
  output chk_state_e       state
);

  chk_state_e state_q, state_d;
  logic       err_q, err_d;
  logic       legal;

  // Judge the current strobe vector and compute next checker state / err.
  always_comb begin
    legal   = 1'b0;
    accept  = 1'b0;
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_LOADED: legal = stb[STB_INIT];
      ST_WAIT_M: legal = stb[STB_M];
      ST_WAIT_R: legal = stb[STB_RES];
      ST_WAIT_A: legal = stb[STB_A];
      default:   legal = 1'b0;
    endcase
    // ldI restarts an evaluation from any state.
    accept = $onehot(stb) && (legal || stb[STB_I]);
    if (accept) begin
      if (stb[STB_I]) begin
        state_d = ST_LOADED;
        err_d   = 1'b0;
      end else begin
        case (state_q)
          ST_LOADED: state_d = ST_WAIT_M;
          ST_WAIT_M: state_d = ST_WAIT_R;
          ST_WAIT_R: state_d = ST_WAIT_A;
          ST_WAIT_A: state_d = n_last ? ST_FIN : ST_WAIT_M;
          default:   state_d = state_q;
        endcase
      end
    end else if (|stb) begin
      err_d = 1'b1;
    end
  end

  // Checker state and sticky error register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err   = err_q;
  assign state = state_q;

endmodule

// File: rtl/taylor_datapath.sv
// Taylor-series e^x datapath in unsigned fixed point, driven by one-hot load
// strobes from the sequencing controller. Each term is produced by an
// ldM (term*x), ldRes (times 1/n) and ldA (accumulate, advance n) triple.
// Optional feature macro: TAYLOR_PROTO_CHECK_EN adds the strobe_checker,
// which rejects out-of-order or simultaneous strobes and flags err; without
// it every strobe is applied unconditionally and err is 0.
module taylor_datapath
  import taylor_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 14,
  parameter int N_TERMS = 8
) (
  input  logic               clk,
  input  logic               rst,
  taylor_datapath_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(one_val(FRAC));
  localparam logic [COEF_DEPTH*COEF_W-1:0] COEF_ROM = build_coef_rom(FRAC, N_TERMS);
  localparam logic [4:0] N_LAST = 5'(N_TERMS - 1);
  localparam logic [4:0] N_MAX  = 5'(N_TERMS);

  logic [WIDTH-1:0] x_q, x_d, term_q, term_d, prod_q, prod_d, sum_q, sum_d;
  logic [4:0]       n_q, n_d;
  logic             done_q, done_d;

  logic [N_STB-1:0]   stb, stb_eff;
  logic               n_last;
  logic [WIDTH-1:0]   coef, prod_nx, term_nx, sum_nx;
  logic [2*WIDTH-1:0] mul_tx, mul_pc, shr_tx, shr_pc;
  logic [WIDTH:0]     sum_ext;

  assign stb[STB_I]    = bus.ldI;
  assign stb[STB_INIT] = bus.ldInit;
  assign stb[STB_M]    = bus.ldM;
  assign stb[STB_RES]  = bus.ldRes;
  assign stb[STB_A]    = bus.ldA;
  assign n_last        = (n_q == N_LAST);

`ifdef TAYLOR_PROTO_CHECK_EN
  logic       chk_accept;
  logic       chk_err;
  chk_state_e chk_state;

  strobe_checker u_strobe_checker (
    .clk    (clk),
    .rst    (rst),
    .stb    (stb),
    .n_last (n_last),
    .accept (chk_accept),
    .err    (chk_err),
    .state  (chk_state)
  );

  assign stb_eff       = chk_accept ? stb : '0;
  assign bus.err       = chk_err;
  assign bus.dbg_state = chk_state;
`else
  assign stb_eff       = stb;
  assign bus.err       = 1'b0;
  assign bus.dbg_state = ST_IDLE;
`endif

  // Arithmetic for each step: products are shifted back to FRAC bits and
  // clamp to all-ones if anything remains above WIDTH bits.
  always_comb begin
    coef    = COEF_ROM[{n_q, 5'b00000} +: WIDTH];
    mul_tx  = {{WIDTH{1'b0}}, term_q} * {{WIDTH{1'b0}}, x_q};
    mul_pc  = {{WIDTH{1'b0}}, prod_q} * {{WIDTH{1'b0}}, coef};
    shr_tx  = mul_tx >> FRAC;
    shr_pc  = mul_pc >> FRAC;
    prod_nx = (|shr_tx[2*WIDTH-1:WIDTH]) ? '1 : shr_tx[WIDTH-1:0];
    term_nx = (|shr_pc[2*WIDTH-1:WIDTH]) ? '1 : shr_pc[WIDTH-1:0];
    sum_ext = {1'b0, sum_q} + {1'b0, term_q};
    sum_nx  = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
  end

  // Register updates selected by the accepted strobes.
  always_comb begin
    x_d    = x_q;
    term_d = term_q;
    prod_d = prod_q;
    sum_d  = sum_q;
    n_d    = n_q;
    done_d = done_q;
    if (stb_eff[STB_I]) begin
      x_d    = bus.x_in;
      done_d = 1'b0;
    end
    if (stb_eff[STB_INIT]) begin
      term_d = ONE;
      sum_d  = ONE;
      n_d    = 5'd1;
      done_d = 1'b0;
    end
    if (stb_eff[STB_M]) prod_d = prod_nx;
    if (stb_eff[STB_RES]) term_d = term_nx;
    if (stb_eff[STB_A]) begin
      sum_d = sum_nx;
      // n stops at N_TERMS even if ldA keeps arriving after the last term.
      if (n_q < N_MAX) n_d = n_q + 5'd1;
      if (n_last) done_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      term_q <= '0;
      prod_q <= '0;
      sum_q  <= '0;
      n_q    <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      term_q <= term_d;
      prod_q <= prod_d;
      sum_q  <= sum_d;
      n_q    <= n_d;
      done_q <= done_d;
    end
  end

  assign bus.Done   = done_q | (stb_eff[STB_A] & n_last);
  assign bus.result = sum_q;

endmodule

// File: tb/tb_taylor_datapath.sv
// Directed bench for taylor_datapath: hand-computed partial sums for
// x = 0, 1.0, 0.5 and saturation, plus protocol-violation and reset cases.
module tb_taylor_datapath;
  import taylor_pkg::*;

  localparam int WIDTH = 16;
  localparam logic [4:0] S_I    = 5'b00001;
  localparam logic [4:0] S_INIT = 5'b00010;
  localparam logic [4:0] S_M    = 5'b00100;
  localparam logic [4:0] S_RES  = 5'b01000;
  localparam logic [4:0] S_A    = 5'b10000;

  logic clk;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  logic [WIDTH-1:0] exp_q[$];

  taylor_datapath_if #(.WIDTH(WIDTH)) bus ();

  taylor_datapath #(.WIDTH(WIDTH), .FRAC(14), .N_TERMS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_strobes();
    bus.ldI = 0; bus.ldInit = 0; bus.ldM = 0; bus.ldRes = 0; bus.ldA = 0;
  endtask

  // Drive one strobe vector for one cycle; Done is sampled mid-cycle.
  task automatic pulse(input logic [4:0] s, output logic done_seen);
    @(negedge clk);
    bus.ldI = s[STB_I]; bus.ldInit = s[STB_INIT]; bus.ldM = s[STB_M];
    bus.ldRes = s[STB_RES]; bus.ldA = s[STB_A];
    #1 done_seen = bus.Done;
    @(posedge clk);
    #1 clear_strobes();
  endtask

  task automatic do_reset();
    clear_strobes();
    bus.x_in = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  // Terms first_k..7; after each ldA the sum is compared with exp_q.
  task automatic run_terms(input int first_k);
    logic d;
    logic [WIDTH-1:0] e;
    for (int k = first_k; k <= 7; k++) begin
      pulse(S_M, d);
      pulse(S_RES, d);
      pulse(S_A, d);
      checks++;
      if (d !== (k == 7)) begin
        fails++;
        $display("FAIL done_during_lda%0d: got %b expected %b", k, d, (k == 7));
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (bus.result !== e) begin
        fails++;
        $display("FAIL sum_term%0d: got %h expected %h", k, bus.result, e);
      end
    end
  endtask

  task automatic run_series(input logic [WIDTH-1:0] x);
    logic d;
    bus.x_in = x;
    pulse(S_I, d);
    pulse(S_INIT, d);
    checks++;
    if (bus.result !== 16'h4000) begin
      fails++;
      $display("FAIL init_sum: got %h expected 4000", bus.result);
    end
    run_terms(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_strobes();
    bus.x_in = '0;
    #12;
    checks++;
    if (bus.result !== 16'h0 || bus.Done !== 1'b0 || bus.err !== 1'b0 ||
        bus.dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got result=%h done=%b err=%b st=%0d expected 0 0 0 0",
               bus.result, bus.Done, bus.err, bus.dbg_state);
    end
    do_reset();
  endtask

  task automatic test_zero();
    for (int k = 0; k < 7; k++) exp_q.push_back(16'h4000);
    run_series(16'h0000);
    checks++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL zero_err: got %b expected 0", bus.err);
    end
  endtask

  task automatic test_one();
    logic [WIDTH-1:0] sums [7] = '{16'h8000, 16'hA000, 16'hAAAA, 16'hAD54,
                                   16'hADDC, 16'hADF2, 16'hADF5};
    int diff;
    for (int k = 0; k < 7; k++) exp_q.push_back(sums[k]);
    run_series(16'h4000);
    diff = int'(bus.result) - 32'hADF8;
    checks++;
    if (diff > 8 || diff < -8) begin
      fails++;
      $display("FAIL e_accuracy: got %h expected ADF8 +/- 8", bus.result);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.Done !== 1'b1 || bus.result !== 16'hADF5) begin
      fails++;
      $display("FAIL done_hold: got done=%b result=%h expected 1 ADF5", bus.Done, bus.result);
    end
  endtask

  // Extra ldA after the final term (state FIN).
  task automatic test_fin_overrun();
    logic d;
    logic [WIDTH-1:0] exp_r;
    logic exp_e;
`ifdef TAYLOR_PROTO_CHECK_EN
    exp_r = 16'hADF5; exp_e = 1'b1;
`else
    exp_r = 16'hADF8; exp_e = 1'b0;
`endif
    pulse(S_A, d);
    checks++;
    if (bus.result !== exp_r || bus.err !== exp_e || bus.Done !== 1'b1) begin
      fails++;
      $display("FAIL fin_overrun: got result=%h err=%b done=%b expected %h %b 1",
               bus.result, bus.err, bus.Done, exp_r, exp_e);
    end
    bus.x_in = 16'h0000;
    pulse(S_I, d);
    checks++;
    if (bus.err !== 1'b0 || bus.Done !== 1'b0) begin
      fails++;
      $display("FAIL ldi_clears: got err=%b done=%b expected 0 0", bus.err, bus.Done);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 7; k++) exp_q.push_back(16'hFFFF);
    run_series(16'hFFFF);
  endtask

  task automatic test_early_strobe();
    logic d;
    logic exp_e;
`ifdef TAYLOR_PROTO_CHECK_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    do_reset();
    pulse(S_M, d);
    checks++;
    if (bus.err !== exp_e || bus.result !== 16'h0) begin
      fails++;
      $display("FAIL early_ldm: got err=%b result=%h expected %b 0000", bus.err, bus.result, exp_e);
    end
`ifdef TAYLOR_PROTO_CHECK_EN
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL early_ldm_state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
    end
`endif
    bus.x_in = 16'h0000;
    pulse(S_I, d);
    checks++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL early_ldi_clear: got %b expected 0", bus.err);
    end
  endtask

  task automatic test_dual_strobe();
    logic d;
    bus.x_in = 16'h4000;
    pulse(S_I, d);
    pulse(S_INIT, d);
    pulse(S_M | S_A, d);
    checks++;
    if (d !== 1'b0) begin
      fails++;
      $display("FAIL dual_done: got %b expected 0", d);
    end
`ifdef TAYLOR_PROTO_CHECK_EN
    checks++;
    if (bus.err !== 1'b1 || bus.result !== 16'h4000 || bus.dbg_state !== ST_WAIT_M) begin
      fails++;
      $display("FAIL dual_reject: got err=%b result=%h st=%0d expected 1 4000 %0d",
               bus.err, bus.result, bus.dbg_state, ST_WAIT_M);
    end
    exp_q.push_back(16'h8000); exp_q.push_back(16'hA000); exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'hAD54); exp_q.push_back(16'hADDC); exp_q.push_back(16'hADF2);
    exp_q.push_back(16'hADF5);
    run_terms(1);
    checks++;
    if (bus.err !== 1'b1) begin
      fails++;
      $display("FAIL dual_err_sticky: got %b expected 1", bus.err);
    end
`else
    checks++;
    if (bus.err !== 1'b0 || bus.result !== 16'h8000) begin
      fails++;
      $display("FAIL dual_apply: got err=%b result=%h expected 0 8000", bus.err, bus.result);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic d;
    logic [WIDTH-1:0] sums [7] = '{16'h6000, 16'h6800, 16'h6955, 16'h697F,
                                   16'h6983, 16'h6983, 16'h6983};
    bus.x_in = 16'h2000;
    pulse(S_I, d);
    pulse(S_INIT, d);
    for (int k = 1; k <= 2; k++) begin
      pulse(S_M, d); pulse(S_RES, d); pulse(S_A, d);
    end
    pulse(S_M, d);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.result !== 16'h0 || bus.Done !== 1'b0 || bus.err !== 1'b0 ||
        bus.dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL async_reset: got result=%h done=%b err=%b st=%0d expected 0 0 0 0",
               bus.result, bus.Done, bus.err, bus.dbg_state);
    end
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back(sums[k]);
    run_series(16'h2000);
    checks++;
    if (bus.Done !== 1'b1 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL restart_done: got done=%b err=%b expected 1 0", bus.Done, bus.err);
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_zero();
    test_one();
    test_fin_overrun();
    test_saturate();
    test_early_strobe();
    test_dual_strobe();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/taylor_datapath.md
# taylor_datapath

Datapath end of the load-strobe control interface: responds to the five one-hot load strobes (`ldI`, `ldInit`, `ldM`, `ldRes`, `ldA`) issued by the sequencing controller and returns `Done`. Evaluates e^x by truncated Taylor series in unsigned fixed point, one term per M/Res/A strobe triple. Sits beside the controller in the accelerator top level; `result` feeds the output register bank.

## Interface
- `WIDTH`, 16: data width, unsigned fixed point.
- `FRAC`, 14: fraction bits; ONE = 1 << FRAC.
- `N_TERMS`, 8: series terms including k=0; legal range 2..16.

- `clk`  input  1  clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `x_in`  input  WIDTH  operand, sampled on `ldI`.
- `ldI`  input  1  load operand.
- `ldInit`  input  1  initialise term, sum and counter.
- `ldM`  input  1  multiply term by x.
- `ldRes`  input  1  scale product by 1/n.
- `ldA`  input  1  accumulate term, advance n.
- `Done`  output  1  last term is being or has been accumulated.
- `result`  output  WIDTH  running sum (e^x when Done).
- `err`  output  1  sticky protocol-violation flag.

## Operation
- Registers: `x_r`, `term`, `prod`, `sum` (WIDTH each), `n` (5 bits), `done_q`, `err`.
- Reset: all registers 0; `Done`=0, `result`=0, `err`=0; checker state IDLE.
- `ldI`: `x_r` <= `x_in`; clears `done_q` and `err`; legal in any checker state.
- `ldInit`: `term` <= ONE, `sum` <= ONE, `n` <= 1, `done_q` <= 0.
- `ldM`: `prod` <= (`term` * `x_r`) >> FRAC, full 2*WIDTH product, truncated, saturated to all-ones if upper bits nonzero.
- `ldRes`: `term` <= (`prod` * COEF[n]) >> FRAC; COEF[n] = floor(ONE / n), constant ROM indexed 1..N_TERMS-1.
- `ldA`: `sum` <= `sum` + `term`, saturating at all-ones; `n` <= `n`+1; `done_q` <= 1 if `n` == N_TERMS-1.
- `Done` = `done_q` | (`ldA` & `n` == N_TERMS-1): combinational so the controller sees it in the cycle `ldA` is high.
- `result` = `sum` continuously.
- Checker FSM (states IDLE, LOADED, WAIT_M, WAIT_R, WAIT_A, FIN): IDLE -ldI-> LOADED -ldInit-> WAIT_M -ldM-> WAIT_R -ldRes-> WAIT_A -ldA-> WAIT_M, or FIN if last term. `ldI` from any state -> LOADED. No strobe: hold.
- Violation = strobe not legal in current state, or two or more strobes high in one cycle. On violation: `err` <= 1, datapath registers and checker state unchanged.

## Timing
- Each strobe takes effect on the rising edge of the cycle it is high; results visible next cycle.
- `Done` valid combinationally during the final `ldA` cycle, then held by `done_q` until next `ldI`/`ldInit` or reset.
- Full evaluation: 2 + 3*(N_TERMS-1) strobe cycles.
- `rst` low mid-iteration: immediate clear; next legal strobe is `ldI` only.
- `n` never exceeds N_TERMS: `ldA` in FIN is a violation.

## Configuration
- `TAYLOR_PROTO_CHECK_EN` defined: checker FSM present, violations rejected and flagged as above.
- Undefined: checker absent, every strobe acted on unconditionally (multiple simultaneous strobes each applied), `err` tied 0; `ldA` in FIN still must not advance `n` past N_TERMS.

## Structure
- Package `taylor_pkg`: checker state enum, ONE/COEF computation function, strobe-vector index constants.
- One sub-module: `strobe_checker` (checker FSM plus `err`), instantiated only under `TAYLOR_PROTO_CHECK_EN`.

## Test plan
- Defaults, x_in=0x0000, legal sequence -> `result`=0x4000, `Done` high during 7th `ldA`, `err`=0.
- x_in=0x4000 (1.0) -> `result` within 8 LSB of 0xADF8 (e), `Done` held after completion.
- x_in=0xFFFF -> `sum` saturates at 0xFFFF, no wrap.
- After reset, `ldM` before `ldI` -> `err`=1, `prod` stays 0; subsequent `ldI` clears `err`.
- `ldM` and `ldA` high together in WAIT_M -> `err`=1, `term`/`sum`/`n` unchanged.
- `rst` low during WAIT_R of term 3 -> all outputs 0 next cycle; fresh sequence with x=0x2000 completes with correct result.
